// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command/response queue front end driving a single-outstanding APB master
module apb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Wait count seen on the edge where the final allowed stalled ACCESS cycle ends.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic       out_of_reset_q;
    logic [7:0] wait_q;
    logic       write_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_rdata_q;
    logic       rsp_err_q;

    logic       accept;
    logic       done_ok;
    logic       done_timeout;

    // out_of_reset_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = out_of_reset_q && (state_q == IDLE) && !rsp_valid_q;

    assign PSEL      = (state_q != IDLE);
    assign PENABLE   = (state_q == ACCESS);
    assign PWRITE    = write_q;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        done_ok      = 1'b0;
        done_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing on the same edge.
                if (PREADY) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    done_timeout = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q        <= IDLE;
            out_of_reset_q <= 1'b0;
            wait_q         <= 8'h00;
            write_q        <= 1'b0;
            addr_q         <= 8'h00;
            wdata_q        <= 8'h00;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 8'h00;
            rsp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_of_reset_q <= 1'b1;

            if (accept) begin
                write_q <= cmd_write;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_write ? cmd_wdata : 8'h00;
                wait_q  <= 8'h00;
            end else if ((state_q == ACCESS) && !PREADY) begin
                wait_q <= wait_q + 8'd1;
            end

            if (done_ok) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= write_q ? 8'h00 : PRDATA;
                rsp_err_q   <= PSLVERR;
            end else if (done_timeout) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= 8'h00;
                rsp_err_q   <= 1'b1;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - directed and randomized transfers against a transaction-level model
module tb_apb_cmd_master;

    localparam int TMO = 16;

    logic       PCLK;
    logic       PRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic       prev_psel   = 1'b0;
    logic       prev_pwrite = 1'b0;
    logic [7:0] prev_paddr  = 8'h00;
    logic [7:0] prev_pwdata = 8'h00;

    apb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply the APB protocol rules there.
    task automatic tick();
        @(negedge PCLK);
        cyc++;
        if (!PRESET) begin
            if (PENABLE) check1("penable_without_psel", PSEL, 1'b1);
            if (PSEL && prev_psel) begin
                check1("pwrite_stable", PWRITE, prev_pwrite);
                check8("paddr_stable", PADDR, prev_paddr);
                check8("pwdata_stable", PWDATA, prev_pwdata);
            end
            prev_psel   = PSEL;
            prev_pwrite = PWRITE;
            prev_paddr  = PADDR;
            prev_pwdata = PWDATA;
        end else begin
            prev_psel = 1'b0;
        end
    endtask

    task automatic drive_junk();
        PREADY  = 1'($urandom);
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
    endtask

    // One command: n_wait low-PREADY ACCESS cycles before the slave answers,
    // hold = cycles the response is left unconsumed (0 = rsp_ready high throughout).
    task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                           input int n_wait, input logic [7:0] rd, input logic serr,
                           input int hold, output int acc_cyc);
        bit         timed_out;
        int         exp_psel;
        logic       exp_err;
        logic [7:0] exp_rdata;
        logic [7:0] exp_pwdata;
        bit         got;
        int         psel_cnt;
        int         access_idx;

        timed_out  = (n_wait >= TMO);
        exp_psel   = 1 + (timed_out ? TMO : n_wait + 1);
        exp_err    = timed_out ? 1'b1 : serr;
        exp_rdata  = (timed_out || wr) ? 8'h00 : rd;
        exp_pwdata = wr ? wd : 8'h00;
        acc_cyc    = -1;

        rsp_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        drive_junk();
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check1("cmd_accepted", got, 1'b1);
        if (!got) begin
            cmd_valid = 1'b0;
            return;
        end
        tick();
        acc_cyc   = cyc;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);

        check1("setup_psel", PSEL, 1'b1);
        check1("setup_penable", PENABLE, 1'b0);
        check1("setup_pwrite", PWRITE, wr);
        check8("setup_paddr", PADDR, a);
        check8("setup_pwdata", PWDATA, exp_pwdata);
        check1("busy_cmd_ready", cmd_ready, 1'b0);

        psel_cnt   = 1;
        access_idx = 0;
        drive_junk();
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!PSEL) break;
            psel_cnt++;
            if (PENABLE) begin
                access_idx++;
                if (access_idx > n_wait) begin
                    PREADY  = 1'b1;
                    PRDATA  = rd;
                    PSLVERR = serr;
                end else begin
                    PREADY  = 1'b0;
                    PRDATA  = 8'($urandom);
                    PSLVERR = 1'($urandom);
                end
            end else begin
                drive_junk();
            end
        end
        drive_junk();

        checki("psel_cycles", psel_cnt, exp_psel);
        check1("done_penable", PENABLE, 1'b0);
        check1("rsp_valid", rsp_valid, 1'b1);
        check1("rsp_err", rsp_err, exp_err);
        check8("rsp_rdata", rsp_rdata, exp_rdata);
        check1("rsp_pending_cmd_ready", cmd_ready, 1'b0);

        for (int h = 0; h < hold; h++) begin
            tick();
            check1("rsp_hold_valid", rsp_valid, 1'b1);
            check1("rsp_hold_err", rsp_err, exp_err);
            check8("rsp_hold_rdata", rsp_rdata, exp_rdata);
            check1("rsp_hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        check1("rsp_consumed", rsp_valid, 1'b0);
        check1("ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        bit got;

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        #1;
        check1("rst_psel", PSEL, 1'b0);
        check1("rst_penable", PENABLE, 1'b0);
        check1("rst_pwrite", PWRITE, 1'b0);
        check8("rst_paddr", PADDR, 8'h00);
        check8("rst_pwdata", PWDATA, 8'h00);
        check1("rst_rsp_valid", rsp_valid, 1'b0);
        check1("rst_rsp_err", rsp_err, 1'b0);
        check8("rst_rsp_rdata", rsp_rdata, 8'h00);
        check1("rst_cmd_ready", cmd_ready, 1'b0);

        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check1("cmd_ready_before_first_edge", cmd_ready, 1'b0);
        tick();
        check1("cmd_ready_after_reset", cmd_ready, 1'b1);

        run_txn(1'b1, 8'h03, 8'h5A, 0, 8'h00, 1'b0, 0, a0);
        run_txn(1'b0, 8'h05, 8'hC3, 3, 8'hA7, 1'b0, 0, a0);
        run_txn(1'b0, 8'h11, 8'h00, 0, 8'h3C, 1'b1, 4, a0);
        run_txn(1'b0, 8'h20, 8'h00, TMO, 8'h99, 1'b0, 0, a0);
        run_txn(1'b1, 8'h21, 8'h77, TMO + 4, 8'h99, 1'b0, 2, a0);
        run_txn(1'b0, 8'h22, 8'h00, TMO - 1, 8'h6B, 1'b0, 0, a0);

        // Reset pulsed while the transfer is stalled in ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h42;
        cmd_wdata = 8'hE1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check1("rst_test_accept", got, 1'b1);
        tick();
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        tick();
        tick();
        check1("rst_test_in_access", PENABLE, 1'b1);
        #2;
        PRESET = 1'b1;
        #1;
        check1("midrst_psel", PSEL, 1'b0);
        check1("midrst_penable", PENABLE, 1'b0);
        check1("midrst_pwrite", PWRITE, 1'b0);
        check8("midrst_paddr", PADDR, 8'h00);
        check8("midrst_pwdata", PWDATA, 8'h00);
        check1("midrst_rsp_valid", rsp_valid, 1'b0);
        check1("midrst_cmd_ready", cmd_ready, 1'b0);
        tick();
        PREADY = 1'b1;
        tick();
        PRESET = 1'b0;
        #1;
        check1("midrst_ready_before_edge", cmd_ready, 1'b0);
        tick();
        check1("midrst_ready_after_edge", cmd_ready, 1'b1);
        check1("midrst_no_response", rsp_valid, 1'b0);
        run_txn(1'b0, 8'h42, 8'h00, 1, 8'h5E, 1'b0, 0, a0);

        // Back-to-back with zero wait states and the response consumed at once.
        run_txn(1'b1, 8'h30, 8'h01, 0, 8'h00, 1'b0, 0, a0);
        run_txn(1'b0, 8'h31, 8'h00, 0, 8'h8F, 1'b0, 0, a1);
        run_txn(1'b1, 8'h32, 8'h03, 0, 8'h00, 1'b1, 0, a2);
        checki("b2b_gap_1", a1 - a0, 4);
        checki("b2b_gap_2", a2 - a1, 4);

        for (int t = 0; t < 12; t++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 20)),
                    8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), a0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
